led_matrix_scanner: RTL and testbench



---
 rtl/led_scan_pkg.sv | 17 +
 rtl/led_matrix_scanner_if.sv | 12 +
 rtl/led_pwm_slot_timer.sv | 49 ++++
 rtl/led_matrix_scanner.sv | 136 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/led_scan_pkg.sv
// Shared FSM state type, counter-width helper and one-hot row decode for the LED matrix scanner.
package led_scan_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} scan_state_t;

    localparam int MAX_ROWS = 256;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_ROWS-1:0] row_onehot(input int unsigned idx);
        return {{(MAX_ROWS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Framebuffer hand-off: producer offers a whole frame with valid, scanner answers with ready.
interface led_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic [ROWS*COLS-1:0] frame_i;
    logic                 frame_valid_i;
    logic                 frame_ready_o;

    modport master (output frame_i, output frame_valid_i, input frame_ready_o);
    modport slave  (input frame_i, input frame_valid_i, output frame_ready_o);
endinterface

// File: rtl/led_pwm_slot_timer.sv
// PWM position inside a row: SLOT_CYCLES clocks per slot, 2^BRIGHT_W slots per row.
// Latency: slot_idx is combinational (position of the coming cycle); no backpressure.
module led_pwm_slot_timer
    import led_scan_pkg::*;
#(
    parameter int BRIGHT_W    = 3,
    parameter int SLOT_CYCLES = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
    output logic [BRIGHT_W-1:0] slot_idx,
    output logic                row_end
);

    localparam int CW = cnt_w(SLOT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

    logic [CW-1:0]       cyc_q, cyc_d;
    logic [BRIGHT_W-1:0] slot_q, slot_d;

    // Counters sit at zero whenever the row is not scanning, so every row starts at slot 0.
    always_comb begin
        cyc_d   = '0;
        slot_d  = '0;
        row_end = advance && (cyc_q == CYC_LAST) && (slot_q == '1);
        if (advance && !row_end) begin
            if (cyc_q == CYC_LAST) begin
                slot_d = slot_q + 1'b1;
            end else begin
                cyc_d  = cyc_q + 1'b1;
                slot_d = slot_q;
            end
        end
    end

    assign slot_idx = slot_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            slot_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning LED matrix driver with double-buffered frames, PWM brightness, blanking; LED_SCAN_ACTIVE_LOW_EN inverts row/col.
// Latency: outputs registered, frame swaps at the LOAD after frame_done_o; backpressure: ready low while shadow is full.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BRIGHT_W     = 3,
    parameter int SLOT_CYCLES  = 128,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    led_matrix_scanner_if.slave      fb,
    input  logic [BRIGHT_W-1:0]      brightness_i,
    output logic [ROWS-1:0]          row_o,
    output logic [COLS-1:0]          col_o,
    output logic [$clog2(ROWS)-1:0]  row_idx_o,
    output logic                     frame_done_o
);

    localparam int RW = $clog2(ROWS);
    localparam int BW = cnt_w(BLANK_CYCLES);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

`ifdef LED_SCAN_ACTIVE_LOW_EN
    localparam logic OFF_LVL = 1'b1;
`else
    localparam logic OFF_LVL = 1'b0;
`endif

    scan_state_t          state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [BRIGHT_W-1:0]  bright_q, bright_d;
    logic [BW-1:0]        blank_q, blank_d;
    logic [ROWS*COLS-1:0] active_q, active_d, shadow_q;
    logic                 shadow_full_q;
    logic                 accept, load_swap, scanning, row_end, lit, done_nxt;
    logic [BRIGHT_W-1:0]  slot_idx;
    logic [ROWS-1:0]      row_nxt;
    logic [COLS-1:0]      col_nxt;

    assign fb.frame_ready_o = !shadow_full_q && rst_n;
    assign accept           = fb.frame_valid_i && fb.frame_ready_o;
    assign load_swap        = (state_q == LOAD) && shadow_full_q;
    assign active_d         = load_swap ? shadow_q : active_q;
    assign scanning         = (state_q == SCAN);
    assign row_idx_o        = row_q;

    led_pwm_slot_timer #(
        .BRIGHT_W    (BRIGHT_W),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (scanning),
        .slot_idx (slot_idx),
        .row_end  (row_end)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        bright_d = bright_q;
        blank_d  = '0;
        if (!enable_i) begin
            state_d = IDLE;
            row_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = LOAD;
                LOAD: begin
                    state_d  = SCAN;
                    row_d    = '0;
                    bright_d = brightness_i;
                end
                SCAN: if (row_end) state_d = BLANK;
                BLANK: begin
                    if (blank_q == BLANK_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = LOAD;
                        end else begin
                            state_d  = SCAN;
                            row_d    = row_q + 1'b1;
                            bright_d = brightness_i;
                        end
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from next-state values so the registered pins line up with the state.
    always_comb begin
        lit      = (state_d == SCAN) && (slot_idx <= bright_d);
        row_nxt  = lit ? ROWS'(row_onehot(32'(row_d))) : '0;
        col_nxt  = lit ? active_d[int'(row_d)*COLS +: COLS] : '0;
        done_nxt = (state_d == BLANK) && (blank_d == BLANK_LAST) && (row_d == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_q         <= '0;
            bright_q      <= '0;
            blank_q       <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            row_o         <= {ROWS{OFF_LVL}};
            col_o         <= {COLS{OFF_LVL}};
            frame_done_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            bright_q <= bright_d;
            blank_q  <= blank_d;
            active_q <= active_d;
            if (accept) begin
                shadow_q      <= fb.frame_i;
                shadow_full_q <= 1'b1;
            end else if (load_swap) begin
                shadow_full_q <= 1'b0;
            end
            row_o        <= row_nxt ^ {ROWS{OFF_LVL}};
            col_o        <= col_nxt ^ {COLS{OFF_LVL}};
            frame_done_o <= done_nxt;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: 4x4 matrix, 2-bit brightness, 2-cycle slots, 1-cycle blank.
`timescale 1ns/1ps
module tb_led_matrix_scanner;

    localparam int ROWS = 4, COLS = 4, BRIGHT_W = 2, SLOT_CYCLES = 2, BLANK_CYCLES = 1;
    localparam int SCAN_CYC  = 8;                     // 2^BRIGHT_W * SLOT_CYCLES
    localparam int ROW_CYC   = SCAN_CYC + BLANK_CYCLES;
    localparam int FRAME_CYC = ROWS * ROW_CYC + 1;    // rows plus the single LOAD cycle
`ifdef LED_SCAN_ACTIVE_LOW_EN
    localparam logic [3:0] INV = 4'hF;
`else
    localparam logic [3:0] INV = 4'h0;
`endif
    localparam logic [15:0] F0 = 16'h8421, FA = 16'h1248, FB = 16'hC3A5, FC = 16'h5A3C, FD = 16'hFFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] brightness = 2'd0;
    logic [3:0] row_o, col_o;
    logic [1:0] row_idx;
    logic       frame_done;
    int         errors = 0;
    int         checks = 0;

    led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) fb();

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .BRIGHT_W(BRIGHT_W),
        .SLOT_CYCLES(SLOT_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .fb           (fb.slave),
        .brightness_i (brightness),
        .row_o        (row_o),
        .col_o        (col_o),
        .row_idx_o    (row_idx),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected pins k cycles after the LOAD->SCAN edge of a frame.
    function automatic logic is_lit(input int k, input int br);
        int p = k % ROW_CYC;
        return (k < ROWS*ROW_CYC) && (p < SCAN_CYC) && ((p / SLOT_CYCLES) <= br);
    endfunction

    function automatic logic [3:0] exp_row(input int k, input int br);
        if (!is_lit(k, br)) return INV;
        return (4'b0001 << (k / ROW_CYC)) ^ INV;
    endfunction

    function automatic logic [3:0] exp_col(input int k, input int br, input logic [15:0] f);
        if (!is_lit(k, br)) return INV;
        return f[(k / ROW_CYC)*4 +: 4] ^ INV;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; fb.frame_valid_i = 1'b0; fb.frame_i = '0;
        step(3);
        checks++; if (row_o !== INV) begin errors++; $display("FAIL reset_row got %b exp %b", row_o, INV); end
        checks++; if (col_o !== INV) begin errors++; $display("FAIL reset_col got %b exp %b", col_o, INV); end
        checks++; if (row_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", row_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
        checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", fb.frame_ready_o); end
        rst_n = 1'b1;
        #1;
        checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", fb.frame_ready_o); end
    endtask

    task automatic test_scan();
        fb.frame_i = F0; fb.frame_valid_i = 1'b1; enable = 1'b1; brightness = 2'd3;
        step();
        fb.frame_valid_i = 1'b0;
        checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL scan_ready_drop got %b exp 0", fb.frame_ready_o); end
        checks++; if (row_o !== INV) begin errors++; $display("FAIL scan_load_row got %b exp %b", row_o, INV); end
        for (int k = 0; k < FRAME_CYC; k++) begin
            step();
            if (k == 0) begin
                checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL scan_ready_back got %b exp 1", fb.frame_ready_o); end
            end
            checks++; if (row_o !== exp_row(k, 3)) begin errors++; $display("FAIL scan_row k=%0d got %b exp %b", k, row_o, exp_row(k, 3)); end
            checks++; if (col_o !== exp_col(k, 3, F0)) begin errors++; $display("FAIL scan_col k=%0d got %b exp %b", k, col_o, exp_col(k, 3, F0)); end
            checks++; if (frame_done !== (k == ROWS*ROW_CYC - 1)) begin errors++; $display("FAIL scan_done k=%0d got %b", k, frame_done); end
            if (k < ROWS*ROW_CYC) begin
                checks++; if (row_idx !== 2'(k / ROW_CYC)) begin errors++; $display("FAIL scan_idx k=%0d got %0d exp %0d", k, row_idx, k / ROW_CYC); end
            end
        end
    endtask

    task automatic test_brightness();
        int lit_cnt [ROWS];
        for (int r = 0; r < ROWS; r++) lit_cnt[r] = 0;
        brightness = 2'd0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            step();
            if (k == 3) brightness = 2'd3;      // mid-row change must be ignored
            if (k == 5) brightness = 2'd0;
            if (k < ROWS*ROW_CYC && (row_o ^ INV) != 4'd0) lit_cnt[k / ROW_CYC]++;
            checks++; if (row_o !== exp_row(k, 0)) begin errors++; $display("FAIL dim_row k=%0d got %b exp %b", k, row_o, exp_row(k, 0)); end
            checks++; if (col_o !== exp_col(k, 0, F0)) begin errors++; $display("FAIL dim_col k=%0d got %b exp %b", k, col_o, exp_col(k, 0, F0)); end
            checks++; if (frame_done !== (k == ROWS*ROW_CYC - 1)) begin errors++; $display("FAIL dim_done k=%0d got %b", k, frame_done); end
        end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (lit_cnt[r] != 2) begin errors++; $display("FAIL dim_lit_count row=%0d got %0d exp 2", r, lit_cnt[r]); end
        end
    endtask

    task automatic test_double_buffer();
        logic [15:0] shown [3];
        shown[0] = F0; shown[1] = FA; shown[2] = FB;
        fb.frame_i = FA; fb.frame_valid_i = 1'b1; brightness = 2'd3;   // accepted on the LOAD edge
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FRAME_CYC; k++) begin
                step();
                if (f == 0) begin
                    if (k == 0) fb.frame_i = FB;
                    checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL dbuf_hold k=%0d got %b exp 0", k, fb.frame_ready_o); end
                end
                if (f == 1 && k == 0) begin
                    checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL dbuf_ready_a got %b exp 1", fb.frame_ready_o); end
                end
                if (f == 1 && k == 1) begin
                    fb.frame_valid_i = 1'b0;
                    checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL dbuf_take_b got %b exp 0", fb.frame_ready_o); end
                end
                if (f == 2 && k == 0) begin
                    checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL dbuf_ready_b got %b exp 1", fb.frame_ready_o); end
                end
                checks++; if (row_o !== exp_row(k, 3)) begin errors++; $display("FAIL dbuf_row f=%0d k=%0d got %b exp %b", f, k, row_o, exp_row(k, 3)); end
                checks++; if (col_o !== exp_col(k, 3, shown[f])) begin errors++; $display("FAIL dbuf_col f=%0d k=%0d got %b exp %b", f, k, col_o, exp_col(k, 3, shown[f])); end
            end
        end
    endtask

    task automatic test_enable_drop();
        step(20);                                  // row 2, second SCAN cycle
        checks++; if (row_o !== (4'b0100 ^ INV)) begin errors++; $display("FAIL en_pre_row got %b exp %b", row_o, 4'b0100 ^ INV); end
        checks++; if (col_o !== (4'b0011 ^ INV)) begin errors++; $display("FAIL en_pre_col got %b exp %b", col_o, 4'b0011 ^ INV); end
        enable = 1'b0;
        step();
        checks++; if (row_o !== INV) begin errors++; $display("FAIL en_off_row got %b exp %b", row_o, INV); end
        checks++; if (col_o !== INV) begin errors++; $display("FAIL en_off_col got %b exp %b", col_o, INV); end
        checks++; if (row_idx !== 2'd0) begin errors++; $display("FAIL en_off_idx got %0d exp 0", row_idx); end
        fb.frame_i = FC; fb.frame_valid_i = 1'b1;
        checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", fb.frame_ready_o); end
        step();
        fb.frame_valid_i = 1'b0;
        checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL idle_accept got %b exp 0", fb.frame_ready_o); end
        step(2);
        checks++; if (row_o !== INV) begin errors++; $display("FAIL idle_row got %b exp %b", row_o, INV); end
        enable = 1'b1;
        step();
        checks++; if (row_o !== INV) begin errors++; $display("FAIL reen_load_row got %b exp %b", row_o, INV); end
        step();
        checks++; if (row_o !== (4'b0001 ^ INV)) begin errors++; $display("FAIL reen_row got %b exp %b", row_o, 4'b0001 ^ INV); end
        checks++; if (col_o !== (4'b1100 ^ INV)) begin errors++; $display("FAIL reen_col got %b exp %b", col_o, 4'b1100 ^ INV); end
        checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL reen_ready got %b exp 1", fb.frame_ready_o); end
    endtask

    task automatic test_reset_mid();
        step(10);
        fb.frame_i = FD; fb.frame_valid_i = 1'b1;
        step();
        fb.frame_valid_i = 1'b0;
        checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL rst_shadow_full got %b exp 0", fb.frame_ready_o); end
        step(3);
        rst_n = 1'b0;
        step();
        checks++; if (row_o !== INV) begin errors++; $display("FAIL rst_mid_row got %b exp %b", row_o, INV); end
        checks++; if (col_o !== INV) begin errors++; $display("FAIL rst_mid_col got %b exp %b", col_o, INV); end
        checks++; if (row_idx !== 2'd0) begin errors++; $display("FAIL rst_mid_idx got %0d exp 0", row_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", frame_done); end
        checks++; if (fb.frame_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b exp 0", fb.frame_ready_o); end
        rst_n = 1'b1;
        #1;
        checks++; if (fb.frame_ready_o !== 1'b1) begin errors++; $display("FAIL rst_rel_ready got %b exp 1", fb.frame_ready_o); end
        step(2);
        checks++; if (row_o !== (4'b0001 ^ INV)) begin errors++; $display("FAIL rst_rel_row got %b exp %b", row_o, 4'b0001 ^ INV); end
        checks++; if (col_o !== INV) begin errors++; $display("FAIL rst_rel_col got %b exp %b", col_o, INV); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_brightness();
        test_double_buffer();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
